// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, ALU operation encodings, instruction field positions and sequencer states
package alu_pkg;
  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_ADDSUB = 3'd1;
  localparam logic [2:0] OP_MUL    = 3'd2;
  localparam logic [2:0] OP_LOGIC  = 3'd3;
  localparam logic [2:0] OP_LSH    = 3'd4;
  localparam logic [2:0] OP_RSH    = 3'd5;
  localparam logic [2:0] OP_LOADI  = 3'd6;
  localparam logic [2:0] OP_STORE  = 3'd7;
  localparam logic [5:0] ALU_ADDSUB = 6'b100001;
  localparam logic [5:0] ALU_MUL    = 6'b100010;
  localparam logic [5:0] ALU_LOGIC  = 6'b100100;
  localparam logic [5:0] ALU_LSH    = 6'b101000;
  localparam logic [5:0] ALU_RSH    = 6'b110000;
  localparam logic [5:0] ALU_LOAD   = 6'b100000;
  localparam int OP_LSB   = 13;
  localparam int RD_LSB   = 10;
  localparam int RS1_LSB  = 7;
  localparam int RS2_LSB  = 4;
  localparam int PRM_LSB  = 0;
  localparam int IMM_FLAG = 3;
  typedef enum logic [2:0] {IDLE, FETCH, IMM, ISSUE, STORE} state_t;
  typedef struct packed {
    logic [5:0] operation;
    logic       read_bus;
    logic       has_imm;
    logic       is_store;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [3:0] prm;
  } decode_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: memory port and ALU control bundle between the sequencer and its neighbours
interface alu_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        alu_readBus;
  logic [15:0] alu_din;
  logic [15:0] alu_dout;
  logic [2:0]  alu_operandIndex1;
  logic [2:0]  alu_operandIndex2;
  logic [2:0]  alu_resultsIndex;
  logic [5:0]  alu_operation;
  logic [3:0]  alu_params;
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, alu_readBus, alu_din,
           alu_operandIndex1, alu_operandIndex2, alu_resultsIndex, alu_operation, alu_params,
    input  mem_rdata, mem_ack, alu_dout
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, alu_readBus, alu_din,
           alu_operandIndex1, alu_operandIndex2, alu_resultsIndex, alu_operation, alu_params,
    output mem_rdata, mem_ack, alu_dout
  );
endinterface

// File: rtl/alu_decode.sv
// alu_decode: maps a 16-bit instruction word onto ALU control fields
module alu_decode
  import alu_pkg::*;
(
  input  logic [15:0] word,
  output decode_t     dec
);
  logic [2:0] op;
  logic       imm_operand;
  always_comb begin
    op = word[OP_LSB +: 3];
    imm_operand = (op inside {OP_ADDSUB, OP_MUL, OP_LOGIC}) && word[IMM_FLAG];
    dec.operation = op == OP_ADDSUB ? ALU_ADDSUB :
                    op == OP_MUL    ? ALU_MUL    :
                    op == OP_LOGIC  ? ALU_LOGIC  :
                    op == OP_LSH    ? ALU_LSH    :
                    op == OP_RSH    ? ALU_RSH    :
                    op == OP_LOADI  ? ALU_LOAD   : 6'd0;
    dec.read_bus = imm_operand || op == OP_LOADI;
    dec.has_imm = imm_operand || op == OP_LOADI || op == OP_STORE;
    dec.is_store = op == OP_STORE;
    dec.rd = word[RD_LSB +: 3];
    dec.rs1 = word[RS1_LSB +: 3];
    dec.rs2 = word[RS2_LSB +: 3];
    dec.prm = word[PRM_LSB +: 4];
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches and decodes instructions, issues one ALU operation each, writes stores back
module alu_sequencer
  import alu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
)(
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          run,
  output logic          busy,
  output logic [15:0]   pc,
  alu_sequencer_if.master bus
);
  state_t      state, state_n;
  decode_t     dec;
  logic        ack;
  logic [15:0] imm;
  logic [5:0]  op_q;
  logic        rb_q, st_q;
  logic [2:0]  rd_q, rs1_q, rs2_q;
  logic [3:0]  prm_q;

  // Read data is decoded live; fields are captured only on the fetch acknowledge.
  alu_decode u_decode (.word(bus.mem_rdata), .dec(dec));

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state <= IDLE;
      pc <= RESET_PC;
      imm <= '0;
      op_q <= '0;
      rb_q <= 1'b0;
      st_q <= 1'b0;
      rd_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      prm_q <= '0;
    end else begin
      state <= state_n;
      if (ack && state != STORE) pc <= pc + 16'd1;
      if (ack && state == FETCH) begin
        op_q <= dec.operation;
        rb_q <= dec.read_bus;
        st_q <= dec.is_store;
        rd_q <= dec.rd;
        rs1_q <= dec.rs1;
        rs2_q <= dec.rs2;
        prm_q <= dec.prm;
      end
      if (ack && state == IMM) imm <= bus.mem_rdata;
    end
  end

  always_comb begin
    ack = bus.mem_ack && (state inside {FETCH, IMM, STORE});
    state_n = state;
    case (state)
      IDLE:    state_n = run ? FETCH : IDLE;
      FETCH:   if (ack) state_n = dec.has_imm ? IMM : dec.operation != 6'd0 ? ISSUE : run ? FETCH : IDLE;
      IMM:     if (ack) state_n = st_q ? STORE : ISSUE;
      ISSUE:   state_n = run ? FETCH : IDLE;
      STORE:   if (ack) state_n = run ? FETCH : IDLE;
      default: state_n = IDLE;
    endcase
    busy = state != IDLE;
    bus.mem_req = state inside {FETCH, IMM, STORE};
    bus.mem_we = state == STORE;
    bus.mem_addr = state == STORE ? imm : (state inside {FETCH, IMM}) ? pc : 16'd0;
    bus.mem_wdata = state == STORE ? bus.alu_dout : 16'd0;
    bus.alu_operation = state == ISSUE ? op_q : 6'd0;
    bus.alu_readBus = state == ISSUE && rb_q;
    bus.alu_din = imm;
    bus.alu_resultsIndex = rd_q;
    bus.alu_operandIndex1 = rs1_q;
    bus.alu_operandIndex2 = rs2_q;
    bus.alu_params = prm_q;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Fetch/decode stage directly upstream of the 8-register ALU.
- Fetches 16-bit instruction words, plus an optional immediate word, from a request/acknowledge memory port.
- Decodes each instruction into the ALU's control fields and issues exactly one ALU operation per instruction.
- Performs register stores by writing the ALU's operand-1 output (alu_dout) back to memory.

Parameters:
- RESET_PC, 16'h0000: program counter value loaded on reset.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RESET_N  in  1  reset, synchronous, active-low.
- run  in  1  high: sequencer fetches continuously. Low: it stops in IDLE after the current instruction finishes.
- busy  out  1  high whenever state != IDLE.
- mem_req  out  1  memory request; held high until mem_ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.
- alu_readBus  out  1  ALU takes operand 2 / load data from alu_din.
- alu_din  out  16  immediate word to the ALU.
- alu_dout  in  16  ALU operand-1 value (store data).
- alu_operandIndex1  out  3  ALU source register 1.
- alu_operandIndex2  out  3  ALU source register 2.
- alu_resultsIndex  out  3  ALU destination register.
- alu_operation  out  6  ALU operation; bit5 = execute strobe.
- alu_params  out  4  ALU parameters.
- pc  out  16  current program counter.

Behaviour:
- Instruction word fields: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] prm.
- Opcodes:
  - 0 NOP
  - 1 ADDSUB: operation 6'b100001
  - 2 MUL: operation 6'b100010
  - 3 LOGIC: operation 6'b100100
  - 4 LSH: operation 6'b101000
  - 5 RSH: operation 6'b110000
  - 6 LOADI: operation 6'b100000, readBus=1
  - 7 STORE
- Immediate word:
  - Present for LOADI, STORE, and for ops 1-3 when prm[3]=1 (operand 2 then comes from the immediate).
  - LSH/RSH never carry an immediate.
- The full prm field is forwarded to alu_params unchanged.
- States: IDLE, FETCH, IMM, ISSUE, STORE.
- IDLE: if run, go to FETCH.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - On mem_ack: latch the instruction, pc <= pc+1.
  - Next state is IMM if an immediate is present; otherwise ISSUE (op 0-5) or back to FETCH/IDLE for NOP (by run).
- IMM:
  - Read at pc, latch the immediate into alu_din, pc <= pc+1.
  - Next state is STORE for op 7, otherwise ISSUE.
- ISSUE:
  - Exactly one cycle with alu_operation = decoded value.
  - alu_readBus=1 for LOADI or immediate-operand instructions.
  - Next state is FETCH if run, else IDLE.
- STORE:
  - mem_req=1, mem_we=1, mem_addr=immediate, mem_wdata=alu_dout with alu_operandIndex1=rs1.
  - alu_operation stays 0 (no writeback).
  - On ack, go to FETCH or IDLE (by run).
- Output timing:
  - alu_operation=0 and alu_readBus=0 in every non-ISSUE cycle.
  - Index/params outputs hold the last decoded values.
- mem_ack handling: sampled as registered; earliest ack is one cycle after mem_req rises. mem_ack while mem_req=0 is ignored.
- Latency (ack after 1 cycle):
  - register op: 3 cycles from FETCH entry to issue
  - immediate op: 5 cycles
  - store: 5 cycles
- pc wraps 16'hFFFF to 16'h0000, including between an instruction word and its immediate.
- run deasserted mid-instruction: the instruction completes and the sequencer then goes to IDLE.
- Reset mid-transaction: the next cycle has mem_req=0, state IDLE, pc=RESET_PC.
- Reset values: busy=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, alu_* outputs all 0, pc=RESET_PC.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_NOP..OP_STORE
  - ALU operation encodings (ALU_ADDSUB 6'b100001 ... ALU_LOAD 6'b100000)
  - field bit positions
  - state enum.
- One natural sub-module, alu_decode: purely combinational, mapping instruction word to {operation, readBus, has_imm, is_store, indices}. It is shared with future disassembly and trace checkers.

Test Plan:
- Reset, run=1, memory[0]=16'h2410 (ADDSUB rd=1 rs1=0 rs2=1 prm=0), ack latency 1 -> mem_req at addr 0; one ISSUE cycle with operation=6'b100001, resultsIndex=1, operandIndex1=0, operandIndex2=1, readBus=0; pc=1.
- memory[0]=16'hC000 (LOADI rd=0), memory[1]=16'h1234 -> two reads (addr 0, 1); ISSUE with operation=6'b100000, readBus=1, alu_din=16'h1234; pc=2.
- memory[0]=16'hE080 (STORE rs1=1), memory[1]=16'h0040, alu_dout=16'hBEEF -> write with mem_we=1, addr=16'h0040, wdata=16'hBEEF; alu_operation never nonzero during the instruction.
- RESET_PC=16'hFFFF, memory[FFFF]=16'h2008 (ADDSUB, immediate), memory[0]=16'h0005 -> immediate read at addr 0; ISSUE with readBus=1, din=5; pc=1.
- Ack latency 4 cycles with a spurious mem_ack while idle -> mem_req and mem_addr stable for 4 cycles; spurious ack causes no state change.
- Drop run during FETCH, then assert RESET_N=0 during a later STORE request -> first instruction issues, then busy=0; after reset, mem_req=0 next cycle and pc=RESET_PC.
